// File: rtl/mux4_scan_pkg.sv
// Shared types and sizing for the 4-way selector scan sampler.
package mux4_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_e;

    typedef logic [NUM_CH-1:0] snap_t;

endpackage

// File: rtl/mux4_scan_sampler_if.sv
// Control, selector and snapshot signals between the scan sampler and its environment.
interface mux4_scan_sampler_if;
    import mux4_scan_pkg::*;

    logic             START;
    logic             ABORT;
    logic             MUX_OUT;
    logic [SEL_W-1:0] SEL;
    snap_t            SAMPLE;
    logic             VALID;
    logic             CHANGED;
    logic             BUSY;

    modport master (
        output START, ABORT, MUX_OUT,
        input  SEL, SAMPLE, VALID, CHANGED, BUSY
    );

    modport slave (
        input  START, ABORT, MUX_OUT,
        output SEL, SAMPLE, VALID, CHANGED, BUSY
    );

endinterface

// File: rtl/scan_settle_timer.sv
// Per-channel settle counter: held at zero while cleared, counts up and saturates at SETTLE_CYCLES.
module scan_settle_timer
    import mux4_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    output logic term_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign term_c = (cnt_q == CNT_W'(SETTLE_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!term_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux4_scan_sampler.sv
// Steps SEL through the four selector channels, samples OUT after a settle window
// and publishes a 4-bit snapshot with VALID and CHANGED pulses.
module mux4_scan_sampler
    import mux4_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          CONTINUOUS    = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    mux4_scan_sampler_if.slave  bus
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [NUM_CH-2:0] shadow_q, shadow_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    snap_t             sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              changed_q, changed_d;
    logic              busy_q, busy_d;
    logic              have_prev_q, have_prev_d;

    logic  term_c;
    logic  go_c;
    snap_t snap_c;

    // Counter sits at zero outside SETTLE, so every channel window starts fresh.
    scan_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr_i  (state_q != SETTLE),
        .term_c (term_c)
    );

    assign go_c   = bus.START || CONTINUOUS;
    assign snap_c = {bus.MUX_OUT, shadow_q};

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        shadow_d    = shadow_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;
        have_prev_d = have_prev_q;

        case (state_q)
            IDLE: begin
                if (!bus.ABORT && go_c) begin
                    state_d = SETTLE;
                    ch_d    = '0;
                end
            end
            SETTLE: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (term_c) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (ch_q == SEL_W'(NUM_CH - 1)) begin
                    sample_d    = snap_c;
                    valid_d     = 1'b1;
                    changed_d   = have_prev_q && (snap_c != sample_q);
                    have_prev_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    for (int i = 0; i < NUM_CH - 1; i++) begin
                        if (ch_q == SEL_W'(i)) begin
                            shadow_d[i] = bus.MUX_OUT;
                        end
                    end
                    ch_d    = ch_q + SEL_W'(1);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                ch_d = '0;
                if (!bus.ABORT && go_c) begin
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        sel_d  = (state_d == SETTLE || state_d == CAPTURE) ? ch_d : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            shadow_q    <= '0;
            sel_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            busy_q      <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            shadow_q    <= shadow_d;
            sel_q       <= sel_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            busy_q      <= busy_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign bus.SEL     = sel_q;
    assign bus.SAMPLE  = sample_q;
    assign bus.VALID   = valid_q;
    assign bus.CHANGED = changed_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_mux4_scan_sampler.sv
// Bench for mux4_scan_sampler: a single-shot instance (SETTLE_CYCLES=1) and a
// free-running instance (SETTLE_CYCLES=0), each driving a 4-way selector.
module tb_mux4_scan_sampler;
    import mux4_scan_pkg::*;

    localparam int S_A = 1;
    localparam int S_B = 0;

    logic       CLK   = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] abcd_a = 4'b1101;
    logic [3:0] abcd_b = 4'b0000;

    int n_vec = 0;
    int n_err = 0;
    int sel_hist [64];

    always #5 CLK = ~CLK;

    mux4_scan_sampler_if bus_a ();
    mux4_scan_sampler_if bus_b ();

    // 4-way selector: OUT follows input {D,C,B,A}[SEL]
    assign bus_a.MUX_OUT = abcd_a[bus_a.SEL];
    assign bus_b.MUX_OUT = abcd_b[bus_b.SEL];

    mux4_scan_sampler #(.SETTLE_CYCLES(S_A), .CONTINUOUS(1'b0)) dut_a (
        .CLK (CLK),
        .RST (rst_a),
        .bus (bus_a)
    );

    mux4_scan_sampler #(.SETTLE_CYCLES(S_B), .CONTINUOUS(1'b1)) dut_b (
        .CLK (CLK),
        .RST (rst_b),
        .bus (bus_b)
    );

    // Model: a scan is a run of 4*(s+2) cycles; channel c owns cycles c*(s+2)+1 .. (c+1)*(s+2)
    // and is sampled in its last one; cycle 4*(s+2)+1 is the snapshot cycle.
    typedef struct {
        bit         active;
        int         k;
        bit [2:0]   shadow;
        bit [3:0]   sample;
        bit         have_prev;
        bit         valid;
        bit         changed;
    } m_t;

    m_t m_a = '{default: 0};
    m_t m_b = '{default: 0};

    function automatic logic [1:0] msel(m_t m, int s);
        if (m.active && m.k <= 4 * (s + 2)) return 2'((m.k - 1) / (s + 2));
        return 2'd0;
    endfunction

    function automatic m_t mstep(m_t m, int s, bit cont, bit rst, bit start, bit abort,
                                 logic [3:0] abcd);
        m_t         n = m;
        int         per = s + 2;
        int         ch;
        bit         b;
        bit [3:0]   snap;
        n.valid   = 0;
        n.changed = 0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (!m.active) begin
            if (!abort && (start || cont)) begin
                n.active = 1;
                n.k      = 1;
            end
        end else if (abort) begin
            n.active = 0;
        end else if (m.k <= 4 * per) begin
            ch = (m.k - 1) / per;
            if (m.k % per == 0) begin
                b = abcd[ch];
                if (ch < 3) begin
                    n.shadow[ch] = b;
                end else begin
                    snap        = {b, m.shadow};
                    n.changed   = m.have_prev && (snap != m.sample);
                    n.sample    = snap;
                    n.valid     = 1;
                    n.have_prev = 1;
                end
            end
            n.k = m.k + 1;
        end else begin
            if (start || cont) n.k = 1;
            else               n.active = 0;
        end
        return n;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            m_a = mstep(m_a, S_A, 1'b0, rst_a, bus_a.START, bus_a.ABORT, abcd_a);
            m_b = mstep(m_b, S_B, 1'b1, rst_b, bus_b.START, bus_b.ABORT, abcd_b);
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            cmp("a.sel",     32'(bus_a.SEL),     32'(msel(m_a, S_A)));
            cmp("a.sample",  32'(bus_a.SAMPLE),  32'(m_a.sample));
            cmp("a.valid",   32'(bus_a.VALID),   32'(m_a.valid));
            cmp("a.changed", 32'(bus_a.CHANGED), 32'(m_a.changed));
            cmp("a.busy",    32'(bus_a.BUSY),    32'(m_a.active));
            cmp("b.sel",     32'(bus_b.SEL),     32'(msel(m_b, S_B)));
            cmp("b.sample",  32'(bus_b.SAMPLE),  32'(m_b.sample));
            cmp("b.valid",   32'(bus_b.VALID),   32'(m_b.valid));
            cmp("b.changed", 32'(bus_b.CHANGED), 32'(m_b.changed));
            cmp("b.busy",    32'(bus_b.BUSY),    32'(m_b.active));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_valid_a(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            sel_hist[i] = int'(bus_a.SEL);
            if (bus_a.VALID === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_valid_b(input int budget, output int cycles, output int drops);
        cycles = -1;
        drops  = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (bus_b.BUSY !== 1'b1) drops++;
            if (bus_b.VALID === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_sel_a(input int want, input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (int'(bus_a.SEL) == want) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic scan_a(input string tag, input logic [3:0] exp_s, input bit exp_c);
        int cyc;
        bus_a.START = 1'b1;
        tick();
        bus_a.START = 1'b0;
        wait_valid_a(40, cyc);
        cmp({tag, ".latency"}, 32'(cyc), 32'd13);
        cmp({tag, ".sample"},  32'(bus_a.SAMPLE), 32'(exp_s));
        cmp({tag, ".changed"}, 32'(bus_a.CHANGED), 32'(exp_c));
        tick();
    endtask

    initial begin
        int  cyc;
        int  drops;
        int  vcnt;
        int  vfirst;
        int  vsecond;
        bit  found;

        bus_a.START = 1'b0;
        bus_a.ABORT = 1'b0;
        bus_b.START = 1'b0;
        bus_b.ABORT = 1'b0;
        repeat (3) tick();
        cmp("rst.sel",    32'(bus_a.SEL),    32'd0);
        cmp("rst.sample", 32'(bus_a.SAMPLE), 32'd0);
        cmp("rst.valid",  32'(bus_a.VALID),  32'd0);
        cmp("rst.busy",   32'(bus_a.BUSY),   32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Free-running instance: 9-cycle period, B toggles flip SAMPLE[1] and pulse CHANGED
        wait_valid_b(20, cyc, drops);
        cmp("cont.first_sample",  32'(bus_b.SAMPLE),  32'd0);
        cmp("cont.first_changed", 32'(bus_b.CHANGED), 32'd0);
        for (int r = 0; r < 4; r++) begin
            abcd_b[1] = ~abcd_b[1];
            wait_valid_b(20, cyc, drops);
            cmp("cont.period",  32'(cyc), 32'd9);
            cmp("cont.busy_drop", 32'(drops), 32'd0);
            cmp("cont.sample1", 32'(bus_b.SAMPLE[1]), 32'(abcd_b[1]));
            cmp("cont.changed", 32'(bus_b.CHANGED), 32'd1);
        end
        tick();

        // First scan: SEL held 3 cycles per channel, snapshot in cycle 13
        scan_a("scan1", 4'b1101, 1'b0);
        for (int i = 1; i <= 12; i++) cmp("scan1.sel_step", 32'(sel_hist[i]), 32'((i - 1) / 3));
        scan_a("scan2", 4'b1101, 1'b0);
        abcd_a = 4'b0101;
        scan_a("scan3", 4'b0101, 1'b1);
        abcd_a = 4'b1101;
        scan_a("scan4", 4'b1101, 1'b1);

        // Abort while SEL==2
        bus_a.START = 1'b1;
        tick();
        bus_a.START = 1'b0;
        wait_sel_a(2, 30, found);
        cmp("abort.reach_sel2", 32'(found), 32'd1);
        bus_a.ABORT = 1'b1;
        @(posedge CLK);
        #2;
        bus_a.ABORT = 1'b0;
        cmp("abort.busy",   32'(bus_a.BUSY),   32'd0);
        cmp("abort.sel",    32'(bus_a.SEL),    32'd0);
        cmp("abort.sample", 32'(bus_a.SAMPLE), 32'(4'b1101));
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (bus_a.VALID === 1'b1) vcnt++;
        end
        cmp("abort.no_valid", 32'(vcnt), 32'd0);
        tick();
        scan_a("abort_rerun", 4'b1101, 1'b0);

        // Reset while SEL==1 discards the scan and clears have_prev
        bus_a.START = 1'b1;
        tick();
        bus_a.START = 1'b0;
        wait_sel_a(1, 30, found);
        cmp("rst_mid.reach_sel1", 32'(found), 32'd1);
        rst_a = 1'b1;
        @(posedge CLK);
        #2;
        rst_a = 1'b0;
        cmp("rst_mid.sel",    32'(bus_a.SEL),    32'd0);
        cmp("rst_mid.sample", 32'(bus_a.SAMPLE), 32'd0);
        cmp("rst_mid.valid",  32'(bus_a.VALID),  32'd0);
        abcd_a = 4'b1111;
        tick();
        scan_a("post_rst", 4'b1111, 1'b0);

        // Mid-scan START pulse must not restart the scan
        bus_a.START = 1'b1;
        tick();
        bus_a.START = 1'b0;
        repeat (4) tick();
        bus_a.START = 1'b1;
        tick();
        bus_a.START = 1'b0;
        wait_valid_a(40, cyc);
        cmp("midstart.latency", 32'(cyc + 5), 32'd13);
        tick();

        // START held high: back-to-back scans through DONE, BUSY never drops
        abcd_a = 4'b0110;
        bus_a.START = 1'b1;
        vcnt = 0; vfirst = 0; vsecond = 0; drops = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (bus_a.BUSY !== 1'b1 && i > 1) drops++;
            if (bus_a.VALID === 1'b1) begin
                vcnt++;
                if (vcnt == 1) vfirst = i;
                if (vcnt == 2) vsecond = i;
            end
        end
        bus_a.START = 1'b0;
        cmp("held.valid_count", 32'(vcnt), 32'd3);
        cmp("held.gap",         32'(vsecond - vfirst), 32'd13);
        cmp("held.busy_drop",   32'(drops), 32'd0);
        wait_valid_a(20, cyc);
        cmp("held.final_sample", 32'(bus_a.SAMPLE), 32'(4'b0110));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
